// File: rtl/msu_pkg.sv
// Shared constants for the MSU-1 data-file buffer between the MCU programming port and the register block.
package msu_pkg;

   localparam int unsigned MSU_BUF_AW    = 14;
   localparam int unsigned MSU_BUF_DW    = 8;
   localparam int unsigned MSU_BUF_DEPTH = 16384;

   localparam logic [MSU_BUF_DW-1:0] MSU_BUF_RESET_DATA = 8'h00;

   typedef logic [MSU_BUF_AW-1:0] msu_buf_addr_t;
   typedef logic [MSU_BUF_DW-1:0] msu_buf_data_t;

endpackage : msu_pkg

// File: rtl/msu_data_buf.sv
// 16 KiB x 8 buffer: MCU write-only port A, SNES read-only port B with a registered, read-first output.
module msu_data_buf
   import msu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MSU_BUF_AW,
   parameter int unsigned DATA_WIDTH = MSU_BUF_DW
) (
   input  logic                  clkin,
   input  logic                  reset,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   input  logic [ADDR_WIDTH-1:0] addrb,
   output logic [DATA_WIDTH-1:0] doutb
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] doutb_d;
   logic [DATA_WIDTH-1:0] doutb_q;

   // Plain synchronous-write array; no reset so it maps onto block RAM.
   always_ff @(posedge clkin) begin
      if (wea && !reset) begin
         mem[addra] <= dina;
      end
   end

   always_comb begin
      doutb_d = mem[addrb];
   end

   // Output register carries the synchronous reset; the old word is captured on a same-address write.
   always_ff @(posedge clkin) begin
      if (reset) begin
         doutb_q <= DATA_WIDTH'(MSU_BUF_RESET_DATA);
      end else begin
         doutb_q <= doutb_d;
      end
   end

   assign doutb = doutb_q;

endmodule : msu_data_buf

// File: tb/tb_msu_data_buf.sv
// Bench for msu_data_buf: directed plan with literal checks plus random traffic against a byte-array model.
module tb_msu_data_buf;

   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic        wea   = 1'b0;
   logic [13:0] addra = '0;
   logic [7:0]  dina  = '0;
   logic [13:0] addrb = '0;
   logic [7:0]  doutb;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Reference: plain byte array; a location is only compared once the bench has written it.
   logic [7:0] m_mem [16384];
   bit         m_vld [16384];

   msu_data_buf dut (
      .clkin (clkin),
      .reset (reset),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .addrb (addrb),
      .doutb (doutb)
   );

   always #5 clkin = ~clkin;

   // Model process: evaluate each edge from the input values seen at that edge, compare 1 ns later.
   initial begin
      logic        r, w;
      logic [13:0] aa, ab;
      logic [7:0]  di, exp_d;
      bit          known;
      forever begin
         @(posedge clkin);
         r = reset; w = wea; aa = addra; ab = addrb; di = dina;
         if (r) begin
            exp_d = 8'h00;
            known = 1'b1;
         end else begin
            exp_d = m_mem[ab];
            known = m_vld[ab];
            if (w) begin
               m_mem[aa] = di;
               m_vld[aa] = 1'b1;
            end
         end
         #1;
         if (known) begin
            vectors++;
            if (doutb !== exp_d) begin
               miscompares++;
               $display("FAIL model t=%0t addrb=%h rst=%0b: doutb=%h expected=%h",
                        $time, ab, r, doutb, exp_d);
            end
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic [13:0] aa,
                        input logic [7:0] di, input logic [13:0] ab);
      @(negedge clkin);
      reset = r; wea = w; addra = aa; dina = di; addrb = ab;
   endtask

   // Literal expectation on doutb just after the next rising edge.
   task automatic check_lit(input string name, input logic [7:0] exp_d);
      @(posedge clkin);
      #2;
      vectors++;
      if (doutb !== exp_d) begin
         miscompares++;
         $display("FAIL %s: doutb=%h expected=%h", name, doutb, exp_d);
      end
   endtask

   initial begin
      // Reset holds doutb at zero.
      drive(1'b1, 1'b0, 14'h0000, 8'h00, 14'h0000);
      @(posedge clkin);
      check_lit("reset_hold", 8'h00);

      // Basic writes including the last entry.
      drive(1'b0, 1'b1, 14'h0000, 8'h53, 14'h2000);
      drive(1'b0, 1'b1, 14'h0001, 8'h2D, 14'h2000);
      drive(1'b0, 1'b1, 14'h3FFF, 8'hFF, 14'h2000);
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h0000);
      check_lit("read_0000", 8'h53);
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h0001);
      check_lit("read_0001", 8'h2D);
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h3FFF);
      check_lit("read_3fff", 8'hFF);

      // Write attempted during reset must be ignored.
      drive(1'b1, 1'b1, 14'h0000, 8'hAA, 14'h0000);
      check_lit("reset_write_out", 8'h00);
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h0000);
      check_lit("reset_write_ignored", 8'h53);

      // Read-first collision.
      drive(1'b0, 1'b1, 14'h0100, 8'h11, 14'h0000);
      drive(1'b0, 1'b1, 14'h0100, 8'h22, 14'h0100);
      check_lit("collision_old", 8'h11);
      drive(1'b0, 1'b0, 14'h0100, 8'h00, 14'h0100);
      check_lit("collision_new", 8'h22);

      // Independent ports on one edge.
      drive(1'b0, 1'b1, 14'h1234, 8'h5A, 14'h0001);
      check_lit("concurrent_read", 8'h2D);
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h1234);
      check_lit("concurrent_write", 8'h5A);

      // Streaming fill then back-to-back sweep with a one-cycle reset pulse mid-way.
      for (int a = 0; a < 256; a++) begin
         drive(1'b0, 1'b1, 14'(a), 8'(a), 14'h3FFF);
      end
      for (int a = 0; a < 256; a++) begin
         if (a == 8'h80) begin
            drive(1'b1, 1'b0, 14'h0000, 8'h00, 14'(a));
            check_lit("sweep_reset", 8'h00);
         end
         drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'(a));
         check_lit("sweep", 8'(a));
      end
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h3FFF);
      check_lit("after_sweep_3fff", 8'hFF);

      // Random traffic: dense windows for collisions, the top boundary, and full range.
      for (int i = 0; i < 3000; i++) begin
         logic [13:0] aa, ab;
         logic        r, w;
         case ($urandom_range(0, 3))
            0:       aa = 14'($urandom_range(0, 15));
            1:       aa = 14'($urandom);
            2:       aa = 14'h3FF0 | 14'($urandom_range(0, 15));
            default: aa = 14'($urandom_range(0, 255));
         endcase
         case ($urandom_range(0, 3))
            0:       ab = aa;
            1:       ab = 14'($urandom_range(0, 15));
            2:       ab = 14'h3FF0 | 14'($urandom_range(0, 15));
            default: ab = 14'($urandom_range(0, 255));
         endcase
         r = ($urandom_range(0, 63) == 0);
         w = ($urandom_range(0, 1) == 1);
         drive(r, w, aa, 8'($urandom), ab);
      end
      drive(1'b0, 1'b0, 14'h0000, 8'h00, 14'h0000);
      @(posedge clkin);
      #3;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_msu_data_buf
